// File: rtl/mult_pkg.sv
// Shared widths and command encodings for the sequential 8x8 multiplier
// (mult_control, mult_datapath and their benches).
package mult_pkg;

    localparam int DW = 8;
    localparam int PW = 16;

    // Nibble-pair selects: first letter picks the A nibble, second the B nibble
    localparam logic [1:0] SEL_LL = 2'b00;
    localparam logic [1:0] SEL_LH = 2'b01;
    localparam logic [1:0] SEL_HL = 2'b10;
    localparam logic [1:0] SEL_HH = 2'b11;

    localparam logic [1:0] SH_0 = 2'b00;
    localparam logic [1:0] SH_4 = 2'b01;
    localparam logic [1:0] SH_8 = 2'b10;

    typedef struct packed {
        logic [3:0] a_nib;
        logic [3:0] b_nib;
    } nib_pair_t;

    // Pick the nibble pair addressed by sel from the two operands
    function automatic nib_pair_t select_nibbles(input logic [1:0]    sel,
                                                 input logic [DW-1:0] a,
                                                 input logic [DW-1:0] b);
        nib_pair_t np;
        np.a_nib = sel[1] ? a[7:4] : a[3:0];
        np.b_nib = sel[0] ? b[7:4] : b[3:0];
        return np;
    endfunction

    // Zero-extend an 8-bit partial product and apply the step's shift;
    // the reserved encoding 2'b11 behaves as no shift
    function automatic logic [PW-1:0] shift_partial(input logic [1:0]      sh,
                                                    input logic [2*4-1:0] pp);
        logic [PW-1:0] ext;
        ext = {{(PW-8){1'b0}}, pp};
        case (sh)
            SH_4:    return ext << 4;
            SH_8:    return ext << 8;
            default: return ext;
        endcase
    endfunction

endpackage

// File: rtl/mult_4x4.sv
// Combinational 4x4 unsigned multiplier producing a full 8-bit product.
module mult_4x4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);

    always_comb begin
        p = {4'b0000, a} * {4'b0000, b};
    end

endmodule

// File: rtl/mult_datapath.sv
// Datapath half of the sequential 8x8 multiplier: operand latch, step counter,
// nibble multiply/shift/accumulate and result capture.
// Optional MULT_DP_OVF_CHECK_EN adds a sticky accumulator-overflow flag (ovf).
module mult_datapath
    import mult_pkg::*;
#(
    parameter int DW = mult_pkg::DW,
    parameter int PW = mult_pkg::PW
) (
    input  logic          clk,
    input  logic          reset_a,
    input  logic          start,
    input  logic [DW-1:0] dataa,
    input  logic [DW-1:0] datab,
    input  logic [1:0]    input_sel,
    input  logic [1:0]    shift_sel,
    input  logic          clk_ena,
    input  logic          sclr_n,
    input  logic          done,
    output logic [1:0]    count,
`ifdef MULT_DP_OVF_CHECK_EN
    output logic          ovf,
`endif
    output logic [PW-1:0] product,
    output logic          result_valid
);

    logic [DW-1:0] a_reg;
    logic [DW-1:0] b_reg;
    logic [PW-1:0] acc;
    nib_pair_t     nibs;
    logic [7:0]    partial;
    logic [PW-1:0] shifted;
    logic [PW-1:0] acc_next;

    always_comb begin
        nibs = select_nibbles(input_sel, a_reg, b_reg);
    end

    mult_4x4 u_mult_4x4 (
        .a (nibs.a_nib),
        .b (nibs.b_nib),
        .p (partial)
    );

    always_comb begin
        shifted = shift_partial(shift_sel, partial);
    end

`ifdef MULT_DP_OVF_CHECK_EN
    logic carry;

    always_comb begin
        {carry, acc_next} = {1'b0, acc} + {1'b0, shifted};
    end

    // Clears win over a same-cycle carry so start/sclr_n always leave ovf low
    always_ff @(posedge clk) begin
        if (!reset_a) begin
            ovf <= 1'b0;
        end else if (!sclr_n || start) begin
            ovf <= 1'b0;
        end else if (clk_ena && carry) begin
            ovf <= 1'b1;
        end
    end
`else
    always_comb begin
        acc_next = acc + shifted;
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset_a) begin
            a_reg        <= '0;
            b_reg        <= '0;
            count        <= '0;
            acc          <= '0;
            product      <= '0;
            result_valid <= 1'b0;
        end else begin
            if (start) begin
                a_reg <= dataa;
                b_reg <= datab;
                count <= '0;
            end else begin
                count <= count + 2'd1;
            end

            if (!sclr_n) begin
                acc <= '0;
            end else if (clk_ena) begin
                acc <= acc_next;
            end

            // Capture the pre-update accumulator value
            if (done) begin
                product <= acc;
            end
            result_valid <= done;
        end
    end

endmodule

// File: tb/tb_mult_datapath.sv
// Self-checking bench for mult_datapath: arithmetic reference model compared
// every cycle, plus hand-computed product expectations.
module tb_mult_datapath;
    import mult_pkg::*;

    logic        clk = 1'b0;
    logic        reset_a;
    logic        start;
    logic [7:0]  dataa;
    logic [7:0]  datab;
    logic [1:0]  input_sel;
    logic [1:0]  shift_sel;
    logic        clk_ena;
    logic        sclr_n;
    logic        done;
    logic [1:0]  count;
    logic [15:0] product;
    logic        result_valid;
`ifdef MULT_DP_OVF_CHECK_EN
    logic        ovf;
`endif

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    int unsigned m_a, m_b, m_cnt, m_acc, m_prod;
    bit          m_valid, m_ovf;

    always #5 clk = ~clk;

    mult_datapath #(.DW(8), .PW(16)) dut (
        .clk          (clk),
        .reset_a      (reset_a),
        .start        (start),
        .dataa        (dataa),
        .datab        (datab),
        .input_sel    (input_sel),
        .shift_sel    (shift_sel),
        .clk_ena      (clk_ena),
        .sclr_n       (sclr_n),
        .done         (done),
        .count        (count),
`ifdef MULT_DP_OVF_CHECK_EN
        .ovf          (ovf),
`endif
        .product      (product),
        .result_valid (result_valid)
    );

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: operands, counter, accumulator as plain integers
    always @(posedge clk) begin
        int unsigned na, nb, part, sum;
        if (!reset_a) begin
            m_a = 0; m_b = 0; m_cnt = 0; m_acc = 0; m_prod = 0;
            m_valid = 0; m_ovf = 0;
        end else begin
            na   = (m_a >> (input_sel[1] ? 4 : 0)) % 16;
            nb   = (m_b >> (input_sel[0] ? 4 : 0)) % 16;
            part = na * nb;
            if (shift_sel == 2'd1) part = part * 16;
            else if (shift_sel == 2'd2) part = part * 256;
            sum = m_acc + part;
            if (!sclr_n || start) m_ovf = 0;
            else if (clk_ena && sum > 65535) m_ovf = 1;
            if (done) m_prod = m_acc;
            m_valid = done;
            if (!sclr_n) m_acc = 0;
            else if (clk_ena) m_acc = sum % 65536;
            m_cnt = start ? 0 : (m_cnt + 1) % 4;
            if (start) begin
                m_a = dataa;
                m_b = datab;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("count", count, m_cnt);
            chk("product", product, m_prod);
            chk("result_valid", result_valid, m_valid);
`ifdef MULT_DP_OVF_CHECK_EN
            chk("ovf", ovf, m_ovf);
`endif
        end
    end

    task automatic idle_inputs();
        start = 0; input_sel = SEL_LL; shift_sel = SH_0;
        clk_ena = 0; sclr_n = 1; done = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step(input logic [1:0] sel, input logic [1:0] sh);
        idle_inputs();
        input_sel = sel; shift_sel = sh; clk_ena = 1;
        tick();
    endtask

    task automatic do_start(input logic [7:0] a, input logic [7:0] b);
        idle_inputs();
        start = 1; sclr_n = 0; dataa = a; datab = b;
        tick();
    endtask

    task automatic do_done();
        idle_inputs();
        done = 1;
        tick();
    endtask

    task automatic run_mult(input logic [7:0] a, input logic [7:0] b,
                            input logic [15:0] exp, input string name);
        do_start(a, b);
        step(SEL_LL, SH_0);
        step(SEL_LH, SH_4);
        step(SEL_HL, SH_4);
        step(SEL_HH, SH_8);
        do_done();
        chk({name, "_product"}, product, exp);
        chk({name, "_valid"}, result_valid, 1);
        idle_inputs();
        tick();
        chk({name, "_valid_drop"}, result_valid, 0);
        chk({name, "_product_hold"}, product, exp);
    endtask

    initial begin
        idle_inputs();
        dataa = 8'h00; datab = 8'h00;
        reset_a = 0;
        start = 1; clk_ena = 1;
        @(negedge clk);
        tick();
        tick();
        cmp_en = 1;
        chk("rst_count", count, 0);
        chk("rst_product", product, 16'h0000);
        chk("rst_valid", result_valid, 0);

        reset_a = 1;
        idle_inputs();
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("free_count", count, i % 4);
        end

        run_mult(8'hC3, 8'h5A, 16'h448E, "nominal");
        run_mult(8'hFF, 8'hFF, 16'hFE01, "ff_ff");
`ifdef MULT_DP_OVF_CHECK_EN
        chk("ovf_clear_before", ovf, 0);
        step(SEL_HH, SH_8);
        chk("ovf_set", ovf, 1);
        idle_inputs();
        tick();
        chk("ovf_sticky", ovf, 1);
        idle_inputs();
        start = 1; dataa = 8'h01; datab = 8'h01;
        tick();
        chk("ovf_start_clear", ovf, 0);
`endif
        run_mult(8'h00, 8'hFF, 16'h0000, "zero");

        // Operands change after start; the registered copies must be used
        do_start(8'h12, 8'h34);
        dataa = 8'hFF; datab = 8'hFF; step(SEL_LL, SH_0);
        dataa = 8'hFF; datab = 8'hFF; step(SEL_LH, SH_4);
        dataa = 8'hFF; datab = 8'hFF; step(SEL_HL, SH_4);
        dataa = 8'hFF; datab = 8'hFF; step(SEL_HH, SH_8);
        do_done();
        chk("hold_product", product, 16'h03A8);

        // sclr_n beats clk_ena mid-sequence
        do_start(8'hC3, 8'h5A);
        step(SEL_LL, SH_0);
        step(SEL_LH, SH_4);
        idle_inputs();
        sclr_n = 0; clk_ena = 1; input_sel = SEL_HH; shift_sel = SH_8;
        tick();
        do_done();
        chk("sclr_priority", product, 16'h0000);
        run_mult(8'hC3, 8'h5A, 16'h448E, "after_clear");

        // start with done: product takes the old accumulator
        idle_inputs();
        start = 1; done = 1; dataa = 8'h01; datab = 8'h01;
        tick();
        chk("start_done_product", product, 16'h448E);
        chk("start_done_count", count, 0);

        // Reset mid-operation
        do_start(8'hC3, 8'h5A);
        step(SEL_LL, SH_0);
        step(SEL_LH, SH_4);
        idle_inputs();
        reset_a = 0; clk_ena = 1; done = 1;
        tick();
        chk("midrst_count", count, 0);
        chk("midrst_product", product, 16'h0000);
        chk("midrst_valid", result_valid, 0);
        reset_a = 1;
        step(SEL_HH, SH_8);
        step(SEL_LL, SH_0);
        do_done();
        chk("midrst_operands_zero", product, 16'h0000);

        idle_inputs();
        tick();
        tick();
        cmp_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
